// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        OVERRIDE = 2'd2
    } led_arb_state_t;

    localparam int LED_W_DEFAULT = 16;
    localparam logic [LED_W_DEFAULT-1:0] LED_ALL_ON = '1;

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N_REQ.
module rr_pick
    import led_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [N_REQ-1:0] pick,
    output logic [IW-1:0]    idx
);

    int j;

    // Scan from the pointer upward and keep only the first hit.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sharing of the LED bank between pattern generators,
// with a one-shot override that lights every LED for one slot.
//
//   state    | meaning
//   IDLE     | blank LEDs, choose next requester or override
//   GRANT    | one requester drives the LEDs for HOLD_TICKS ticks
//   OVERRIDE | all LEDs on for HOLD_TICKS ticks
module led_bank_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LED_W      = LED_W_DEFAULT,
    parameter int TICK_DIV   = 25_000_000,
    parameter int HOLD_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LED_W-1:0] pattern,
    input  logic                   ovr,
    output logic [LED_W-1:0]       led,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       slot_done,
    output logic                   busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

    led_arb_state_t   state_q, state_d;
    logic [PW-1:0]    presc_q;
    logic [HW-1:0]    hold_q;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_after;
    logic [LED_W-1:0] led_d;
    logic [N_REQ-1:0] grant_d, done_d;
    logic             cnt_clr, tick, slot_end;
    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .pick  (pick_onehot),
        .idx   (pick_idx)
    );

    assign tick      = (presc_q == PRESC_MAX);
    assign slot_end  = tick && (hold_q == HOLD_MAX);
    assign ptr_after = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
    assign busy      = (state_q != IDLE);

    // Next state and next registered outputs; leaving to IDLE always blanks.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        led_d   = '0;
        grant_d = '0;
        done_d  = '0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (ovr) begin
                    state_d = OVERRIDE;
                    led_d   = {LED_W{LED_ALL_ON[0]}};
                    cnt_clr = 1'b1;
                end else if (pick_valid) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    grant_d = pick_onehot;
                    led_d   = pattern[int'(pick_idx)*LED_W +: LED_W];
                    cnt_clr = 1'b1;
                end
            end
            GRANT: begin
                if (ovr) begin
                    // Pointer stays put so the preempted requester goes next.
                    state_d = OVERRIDE;
                    led_d   = {LED_W{LED_ALL_ON[0]}};
                    cnt_clr = 1'b1;
                end else if (!req[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end else if (slot_end) begin
                    state_d       = IDLE;
                    ptr_d         = ptr_after;
                    done_d[idx_q] = 1'b1;
                end else begin
                    grant_d = grant;
                    led_d   = pattern[int'(idx_q)*LED_W +: LED_W];
                end
            end
            OVERRIDE: begin
                if (ovr) begin
                    led_d   = {LED_W{LED_ALL_ON[0]}};
                    cnt_clr = 1'b1;
                end else if (slot_end) begin
                    state_d = IDLE;
                end else begin
                    led_d = {LED_W{LED_ALL_ON[0]}};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            led       <= '0;
            grant     <= '0;
            slot_done <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            led       <= led_d;
            grant     <= grant_d;
            slot_done <= done_d;
        end
    end

    // Prescaler and hold counter; both restart whenever a slot begins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            presc_q <= '0;
            hold_q  <= '0;
        end else if (tick) begin
            presc_q <= '0;
            hold_q  <= (hold_q == HOLD_MAX) ? '0 : hold_q + HW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter with a short tick (4 cycles)
// and 2 ticks per slot, so a full slot lasts 8 cycles.
module tb_led_bank_arbiter;

    localparam int N_REQ      = 4;
    localparam int LED_W      = 16;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int SLOT       = TICK_DIV * HOLD_TICKS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LED_W-1:0] pattern;
    logic                   ovr;
    logic [LED_W-1:0]       led;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       slot_done;
    logic                   busy;

    typedef struct {
        logic [N_REQ-1:0] grant;
        logic [LED_W-1:0] led;
        int               len;
        logic [N_REQ-1:0] done;
        logic [LED_W-1:0] blank;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [N_REQ-1:0] mon_cur = '0;
    int               mon_len = 0;
    logic [LED_W-1:0] mon_led = '0;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .N_REQ(N_REQ), .LED_W(LED_W), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern), .ovr(ovr),
        .led(led), .grant(grant), .slot_done(slot_done), .busy(busy)
    );

    function automatic logic [LED_W-1:0] pat(int i);
        logic [LED_W-1:0] base;
        base = 16'h000F;
        return base << (4 * i);
    endfunction

    function automatic seg_t mk(int i, int len, bit full, logic [LED_W-1:0] blank);
        seg_t s;
        s.grant = N_REQ'(1 << i);
        s.led   = pat(i);
        s.len   = len;
        s.done  = full ? s.grant : '0;
        s.blank = blank;
        return s;
    endfunction

    // Monitor: records each grant interval and what follows it.
    always begin
        seg_t s;
        @(posedge clk);
        #2;
        if (mon_cur != 0 && grant != mon_cur) begin
            s.grant = mon_cur; s.led = mon_led; s.len = mon_len;
            s.done = slot_done; s.blank = led;
            obs_q.push_back(s);
            mon_cur = '0;
        end
        if (mon_cur == 0 && grant != 0) begin
            mon_cur = grant; mon_len = 1; mon_led = led;
        end else if (mon_cur != 0) begin
            mon_len++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        rst = 1'b1; req = '0; ovr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; ovr = 1'b0;
        tick(); tick(); tick();
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h want 0000", led); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (slot_done !== 4'b0) begin errors++; $display("FAIL reset_done got %b want 0000", slot_done); end
        rst = 1'b0; req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", grant); end
        checks++; if (led !== pat(0)) begin errors++; $display("FAIL first_led got %h want %h", led, pat(0)); end
        for (int k = 0; k < SLOT; k++) tick();
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL slot_end_grant got %b want 0000", grant); end
        checks++; if (slot_done !== 4'b0001) begin errors++; $display("FAIL slot_end_done got %b want 0001", slot_done); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL slot_end_blank got %h want 0000", led); end
        tick();
        req = 4'b0011;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL midrst_led got %h want 0000", led); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL midrst_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ptr_reset got %b want 0001", grant); end
    endtask

    task automatic test_round_robin();
        seg_t e, o;
        int n;
        rst_dut();
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(k % N_REQ, SLOT, 1'b1, 16'h0));
        req = 4'b1111;
        n = 0;
        while (obs_q.size() < 5 && n < 120) begin tick(); n++; end
        checks++; if (obs_q.size() < 5) begin errors++; $display("FAIL rr_timeout got %0d slots want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.grant !== e.grant) begin errors++; $display("FAIL rr_grant got %b want %b", o.grant, e.grant); end
            checks++; if (o.led !== e.led) begin errors++; $display("FAIL rr_led got %h want %h", o.led, e.led); end
            checks++; if (o.len !== e.len) begin errors++; $display("FAIL rr_len got %0d want %0d", o.len, e.len); end
            checks++; if (o.done !== e.done) begin errors++; $display("FAIL rr_done got %b want %b", o.done, e.done); end
            checks++; if (o.blank !== e.blank) begin errors++; $display("FAIL rr_blank got %h want %h", o.blank, e.blank); end
        end
        exp_q.delete();
        req = '0;
    endtask

    task automatic test_skip();
        seg_t e, o;
        int n;
        rst_dut();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk((k % 2) ? 3 : 1, SLOT, 1'b1, 16'h0));
        req = 4'b1010;
        n = 0;
        while (obs_q.size() < 4 && n < 100) begin tick(); n++; end
        checks++; if (obs_q.size() < 4) begin errors++; $display("FAIL skip_timeout got %0d slots want 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.grant !== e.grant) begin errors++; $display("FAIL skip_grant got %b want %b", o.grant, e.grant); end
            checks++; if (o.len !== e.len) begin errors++; $display("FAIL skip_len got %0d want %0d", o.len, e.len); end
            checks++; if (o.done !== e.done) begin errors++; $display("FAIL skip_done got %b want %b", o.done, e.done); end
        end
        exp_q.delete();
        req = '0;
    endtask

    task automatic test_early_release();
        seg_t e, o;
        int n;
        rst_dut();
        req = 4'b0110;
        n = 0;
        while (grant == 0 && n < 20) begin tick(); n++; end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL er_start got %b want 0010", grant); end
        tick(); tick();
        req = 4'b0100;
        exp_q.push_back(mk(1, 3, 1'b0, 16'h0));
        exp_q.push_back(mk(2, SLOT, 1'b1, 16'h0));
        n = 0;
        while (obs_q.size() < 2 && n < 60) begin tick(); n++; end
        checks++; if (obs_q.size() < 2) begin errors++; $display("FAIL er_timeout got %0d slots want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.grant !== e.grant) begin errors++; $display("FAIL er_grant got %b want %b", o.grant, e.grant); end
            checks++; if (o.len !== e.len) begin errors++; $display("FAIL er_len got %0d want %0d", o.len, e.len); end
            checks++; if (o.done !== e.done) begin errors++; $display("FAIL er_done got %b want %b", o.done, e.done); end
        end
        exp_q.delete();
        req = '0;
    endtask

    task automatic test_override_preempt();
        seg_t e, o;
        int n;
        bit bad;
        rst_dut();
        req = 4'b1100;
        n = 0;
        while (grant == 0 && n < 20) begin tick(); n++; end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ovp_start got %b want 0100", grant); end
        tick(); tick(); tick(); tick();
        ovr = 1'b1;
        exp_q.push_back(mk(2, 5, 1'b0, 16'hFFFF));
        exp_q.push_back(mk(2, SLOT, 1'b1, 16'h0));
        exp_q.push_back(mk(3, SLOT, 1'b1, 16'h0));
        tick();
        ovr = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovp_busy got %b want 1", busy); end
        n = 0; bad = 1'b0;
        while (led === 16'hFFFF && n < 40) begin
            if (grant !== 4'b0) bad = 1'b1;
            n++;
            tick();
        end
        checks++; if (n !== SLOT) begin errors++; $display("FAIL ovp_len got %0d want %0d", n, SLOT); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ovp_grant_zero got %b want 0", bad); end
        n = 0;
        while (obs_q.size() < 3 && n < 60) begin tick(); n++; end
        checks++; if (obs_q.size() < 3) begin errors++; $display("FAIL ovp_timeout got %0d slots want 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.grant !== e.grant) begin errors++; $display("FAIL ovp_grant got %b want %b", o.grant, e.grant); end
            checks++; if (o.len !== e.len) begin errors++; $display("FAIL ovp_slen got %0d want %0d", o.len, e.len); end
            checks++; if (o.done !== e.done) begin errors++; $display("FAIL ovp_done got %b want %b", o.done, e.done); end
            checks++; if (o.blank !== e.blank) begin errors++; $display("FAIL ovp_after got %h want %h", o.blank, e.blank); end
        end
        exp_q.delete();
        req = '0;
    endtask

    task automatic test_override_extend();
        int n;
        rst_dut();
        ovr = 1'b1;
        tick();
        ovr = 1'b0;
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL ovx_first got %h want ffff", led); end
        n = 0;
        while (led === 16'hFFFF && n < 40) begin
            n++;
            ovr = (n == 6);
            tick();
            ovr = 1'b0;
        end
        checks++; if (n !== 6 + SLOT) begin errors++; $display("FAIL ovx_len got %0d want %0d", n, 6 + SLOT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovx_idle got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int n;
        rst_dut();
        req = 4'b0001;
        ovr = 1'b1;
        tick();
        ovr = 1'b0;
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL sim_led got %h want ffff", led); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL sim_grant got %b want 0000", grant); end
        n = 0;
        while (led === 16'hFFFF && n < 40) begin n++; tick(); end
        checks++; if (n !== SLOT) begin errors++; $display("FAIL sim_len got %0d want %0d", n, SLOT); end
        checks++; if (grant !== 4'b0 || led !== 16'h0) begin errors++; $display("FAIL sim_gap got %b/%h want 0000/0000", grant, led); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sim_after got %b want 0001", grant); end
        checks++; if (led !== pat(0)) begin errors++; $display("FAIL sim_after_led got %h want %h", led, pat(0)); end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; ovr = 1'b0;
        for (int i = 0; i < N_REQ; i++) pattern[i*LED_W +: LED_W] = pat(i);
        test_reset();
        test_round_robin();
        test_skip();
        test_early_release();
        test_override_preempt();
        test_override_extend();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
